audio_frame_streamer: RTL and testbench



---
 rtl/audio_frame_streamer.sv | 181 ++++++++++++++++++
 tb/tb_audio_frame_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_streamer.sv
// Host-side frame initiator: packs samples into processor chunks, runs one frame, unpacks the result.
// Define STREAMER_TIMEOUT_EN to add a sticky watchdog over the busy/done wait.
module audio_frame_streamer #(
  parameter int SIZE           = 16,
  parameter int INPUT_SIZE     = 512,
  parameter int SAMPLES        = 2048,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int CHUNKS        = SAMPLES * SIZE / INPUT_SIZE,
  localparam int SPC           = INPUT_SIZE / SIZE,
  localparam int IW            = $clog2(CHUNKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE-1:0]       s_in_data,
  input  logic                  s_in_valid,
  output logic                  s_in_ready,
  output logic [SIZE-1:0]       s_out_data,
  output logic                  s_out_valid,
  input  logic                  s_out_ready,
  output logic                  s_out_last,
  output logic                  proc_data_wr_en,
  output logic [IW-1:0]         proc_input_index,
  output logic [INPUT_SIZE-1:0] proc_data_in,
  output logic                  proc_start,
  input  logic                  proc_done,
  output logic [IW-1:0]         proc_output_index,
  input  logic [INPUT_SIZE-1:0] proc_data_out,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  timeout_err
);

  localparam int SW = (SPC > 1) ? $clog2(SPC) : 1;
  localparam int LW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  typedef enum logic [2:0] {FILL, WRITE, START, WAIT_BUSY, WAIT_DONE, RD_WAIT, DRAIN} state_t;

  state_t                state;
  logic [SW-1:0]         samp_cnt;
  logic [SW-1:0]         slot_nxt;
  logic [IW-1:0]         chunk_cnt;
  logic [LW-1:0]         lat_cnt;
  logic [INPUT_SIZE-1:0] unpack_reg;
  logic                  rd_capture;
  logic                  last_chunk;
  logic                  wd_expire;

  assign rd_capture = (state == RD_WAIT) && (lat_cnt == LW'(READ_LATENCY));
  assign slot_nxt   = samp_cnt + 1'b1;
  assign last_chunk = (proc_output_index == IW'(CHUNKS - 1));

`ifdef STREAMER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;

  assign wd_expire = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                     (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == WAIT_BUSY) || (state == WAIT_DONE)) wd_cnt <= wd_cnt + 1'b1;
      else                                              wd_cnt <= '0;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Read-back chunk holding register; only meaningful while draining
  always_ff @(posedge clk) begin
    if (rd_capture) unpack_reg <= proc_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= FILL;
      samp_cnt          <= '0;
      chunk_cnt         <= '0;
      lat_cnt           <= '0;
      s_in_ready        <= 1'b1;
      s_out_valid       <= 1'b0;
      s_out_last        <= 1'b0;
      s_out_data        <= '0;
      proc_data_wr_en   <= 1'b0;
      proc_start        <= 1'b0;
      proc_input_index  <= '0;
      proc_output_index <= '0;
      proc_data_in      <= '0;
      busy              <= 1'b0;
      frame_count       <= '0;
    end else begin
      case (state)
        FILL: if (s_in_valid && s_in_ready) begin
          proc_data_in[samp_cnt*SIZE +: SIZE] <= s_in_data;
          if (samp_cnt == SW'(SPC - 1)) begin
            samp_cnt         <= '0;
            state            <= WRITE;
            s_in_ready       <= 1'b0;
            busy             <= 1'b1;
            proc_data_wr_en  <= 1'b1;
            proc_input_index <= chunk_cnt;
          end else begin
            samp_cnt <= slot_nxt;
          end
        end
        WRITE: begin
          proc_data_wr_en <= 1'b0;
          if (chunk_cnt == IW'(CHUNKS - 1)) begin
            chunk_cnt  <= '0;
            state      <= START;
            proc_start <= 1'b1;
          end else begin
            chunk_cnt  <= chunk_cnt + 1'b1;
            state      <= FILL;
            s_in_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        START: begin
          proc_start <= 1'b0;
          state      <= WAIT_BUSY;
        end
        // done is high while the processor idles, so first wait for it to drop
        WAIT_BUSY: if (wd_expire) begin
          state      <= FILL;
          s_in_ready <= 1'b1;
          busy       <= 1'b0;
        end else if (!proc_done) begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: if (wd_expire) begin
          state      <= FILL;
          s_in_ready <= 1'b1;
          busy       <= 1'b0;
        end else if (proc_done) begin
          proc_output_index <= '0;
          lat_cnt           <= '0;
          state             <= RD_WAIT;
        end
        RD_WAIT: if (rd_capture) begin
          state       <= DRAIN;
          samp_cnt    <= '0;
          s_out_valid <= 1'b1;
          s_out_data  <= proc_data_out[SIZE-1:0];
          s_out_last  <= (SPC == 1) && last_chunk;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        DRAIN: if (s_out_ready) begin
          if (samp_cnt == SW'(SPC - 1)) begin
            samp_cnt    <= '0;
            s_out_valid <= 1'b0;
            s_out_last  <= 1'b0;
            if (last_chunk) begin
              frame_count <= frame_count + 1'b1;
              state       <= FILL;
              s_in_ready  <= 1'b1;
              busy        <= 1'b0;
            end else begin
              proc_output_index <= proc_output_index + 1'b1;
              lat_cnt           <= '0;
              state             <= RD_WAIT;
            end
          end else begin
            samp_cnt   <= slot_nxt;
            s_out_data <= unpack_reg[slot_nxt*SIZE +: SIZE];
            s_out_last <= last_chunk && (slot_nxt == SW'(SPC - 1));
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_streamer.sv
// Bench for audio_frame_streamer: echoing processor stub, random samples, queue-based reference.
module tb_audio_frame_streamer;
  localparam int SIZE = 16, INPUT_SIZE = 512, SAMPLES = 2048, RL = 2;
  localparam int SPC = INPUT_SIZE / SIZE, CHUNKS = SAMPLES / SPC, IW = $clog2(CHUNKS);

  logic                  clk = 1'b0, rst = 1'b1;
  logic [SIZE-1:0]       s_in_data = '0, s_out_data;
  logic                  s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_out_last;
  logic                  proc_data_wr_en, proc_start, proc_done = 1'b1, busy, timeout_err;
  logic [IW-1:0]         proc_input_index, proc_output_index;
  logic [INPUT_SIZE-1:0] proc_data_in, proc_data_out;
  logic [15:0]           frame_count;

  audio_frame_streamer #(.SIZE(SIZE), .INPUT_SIZE(INPUT_SIZE), .SAMPLES(SAMPLES),
                         .READ_LATENCY(RL), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
    .s_out_data(s_out_data), .s_out_valid(s_out_valid), .s_out_ready(s_out_ready), .s_out_last(s_out_last),
    .proc_data_wr_en(proc_data_wr_en), .proc_input_index(proc_input_index), .proc_data_in(proc_data_in),
    .proc_start(proc_start), .proc_done(proc_done), .proc_output_index(proc_output_index),
    .proc_data_out(proc_data_out), .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err));

  initial forever #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  logic [SIZE-1:0] in_s [SAMPLES];

  // Processor stub: stores chunks, echoes them back with RL cycles of read latency
  logic [INPUT_SIZE-1:0] mem [CHUNKS];
  logic [INPUT_SIZE-1:0] pipe0, pipe1;
  int stub_t = 0;
  bit hang = 1'b0;
`ifdef STREAMER_TIMEOUT_EN
  int busy_len = 60;
`else
  int busy_len = 200;
`endif
  assign proc_data_out = pipe1;
  always @(posedge clk) begin
    if (proc_data_wr_en) mem[proc_input_index] <= proc_data_in;
    pipe0 <= mem[proc_output_index];
    pipe1 <= pipe0;
    if (proc_start) stub_t <= 1;
    else if (stub_t != 0) stub_t <= stub_t + 1;
    if (stub_t == 3 && !hang) proc_done <= 1'b0;
    if (stub_t == 3 + busy_len) begin proc_done <= 1'b1; stub_t <= 0; end
  end

  // Event recorders (sampled on the falling edge)
  logic [IW-1:0]         wr_idx_q [$];
  logic [INPUT_SIZE-1:0] wr_dat_q [$];
  logic [SIZE-1:0]       out_q [$];
  bit                    last_q [$];
  int  start_cnt = 0, overlap_cnt = 0, stall_viol = 0, proto_viol = 0;
  bit  rec_on = 1'b0, stall_prev = 1'b0;
  logic [SIZE-1:0] stall_dat = '0;
  always @(negedge clk) if (rec_on) begin
    if (proc_data_wr_en) begin wr_idx_q.push_back(proc_input_index); wr_dat_q.push_back(proc_data_in); end
    if (proc_start) start_cnt++;
    if (proc_start && proc_data_wr_en) overlap_cnt++;
    if (s_out_valid && s_out_ready) begin out_q.push_back(s_out_data); last_q.push_back(s_out_last); end
    if (s_out_valid && stall_prev && (s_out_data !== stall_dat)) stall_viol++;
    stall_prev = s_out_valid && !s_out_ready;
    stall_dat  = s_out_data;
    if (s_in_ready === busy) proto_viol++;
    if ((proc_data_wr_en || s_out_valid) && !busy) proto_viol++;
  end

  task automatic clear_rec();
    wr_idx_q.delete(); wr_dat_q.delete(); out_q.delete(); last_q.delete();
    start_cnt = 0; overlap_cnt = 0; stall_viol = 0; proto_viol = 0;
  endtask

  function automatic logic [INPUT_SIZE-1:0] exp_chunk(int c);
    logic [INPUT_SIZE-1:0] w = '0;
    for (int k = 0; k < SPC; k++) w[SIZE*k +: SIZE] = in_s[c*SPC + k];
    return w;
  endfunction

  function automatic int bad_writes();
    int b = 0;
    for (int i = 0; i < CHUNKS; i++)
      if (i >= wr_idx_q.size() || wr_idx_q[i] !== IW'(i) || wr_dat_q[i] !== exp_chunk(i)) b++;
    return b;
  endfunction

  function automatic int bad_outputs();
    int b = 0;
    for (int i = 0; i < SAMPLES; i++)
      if (i >= out_q.size() || out_q[i] !== in_s[i]) b++;
    return b;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < SAMPLES; i++) in_s[i] = SIZE'($urandom);
  endtask

  task automatic drive_frame(input bit gaps, input bit bp, input bit stop_on_start);
    int idx = 0, cyc = 0;
    bit rdy_prev = 1'b0;
    s_in_valid = 1'b0;
    while (cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      if (stop_on_start ? (start_cnt > 0) : (out_q.size() >= SAMPLES)) break;
      if (s_in_valid && rdy_prev) idx++;
      rdy_prev    = s_in_ready;
      s_in_valid  = (idx < SAMPLES) && !(gaps && (cyc % 3 == 0));
      s_in_data   = (idx < SAMPLES) ? in_s[idx] : '0;
      s_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if ({s_in_ready, s_out_valid, s_out_last, proc_data_wr_en, proc_start, busy, timeout_err} !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1000000", {s_in_ready, s_out_valid, s_out_last, proc_data_wr_en, proc_start, busy, timeout_err}); end
    n_vec++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_vec++; if ({proc_input_index, proc_output_index} !== '0) begin
      n_fail++; $display("FAIL reset_indices: got %0d/%0d want 0/0", proc_input_index, proc_output_index); end
    n_vec++; if (proc_data_in !== '0 || s_out_data !== '0) begin n_fail++; $display("FAIL reset_data: nonzero data, want 0"); end
    clear_rec();
    rec_on = 1'b1;
  endtask

  task automatic test_full_frame();
    int nl = 0, lp = -1, bw, bo;
    for (int i = 0; i < SAMPLES; i++) in_s[i] = SIZE'(i);
    clear_rec();
    drive_frame(1'b0, 1'b0, 1'b0);
    bw = bad_writes(); bo = bad_outputs();
    n_vec++; if (wr_idx_q.size() != CHUNKS) begin n_fail++; $display("FAIL ff_write_count: got %0d want %0d", wr_idx_q.size(), CHUNKS); end
    n_vec++; if (bw != 0) begin n_fail++; $display("FAIL ff_write_chunks: %0d bad, want 0", bw); end
    if (wr_dat_q.size() > 0) begin
      n_vec++; if (wr_dat_q[0][15:0] !== 16'd0 || wr_dat_q[0][511:496] !== 16'd31) begin
        n_fail++; $display("FAIL ff_chunk0_order: got %0d/%0d want 0/31", wr_dat_q[0][15:0], wr_dat_q[0][511:496]); end
    end
    n_vec++; if (start_cnt != 1 || overlap_cnt != 0) begin n_fail++; $display("FAIL ff_start: got %0d starts %0d overlaps want 1/0", start_cnt, overlap_cnt); end
    n_vec++; if (out_q.size() != SAMPLES) begin n_fail++; $display("FAIL ff_out_count: got %0d want %0d", out_q.size(), SAMPLES); end
    n_vec++; if (bo != 0) begin n_fail++; $display("FAIL ff_out_data: %0d bad samples, want 0", bo); end
    for (int i = 0; i < last_q.size(); i++) if (last_q[i]) begin nl++; lp = i; end
    n_vec++; if (nl != 1 || lp != SAMPLES - 1) begin n_fail++; $display("FAIL ff_last: got %0d lasts at %0d want 1 at %0d", nl, lp, SAMPLES - 1); end
    n_vec++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL ff_frame_count: got %0d want 1", frame_count); end
    n_vec++; if (proto_viol != 0) begin n_fail++; $display("FAIL ff_protocol: %0d violations want 0", proto_viol); end
  endtask

  task automatic test_backpressure();
    int bo;
    fill_random(); clear_rec();
    drive_frame(1'b0, 1'b1, 1'b0);
    bo = bad_outputs();
    n_vec++; if (out_q.size() != SAMPLES) begin n_fail++; $display("FAIL bp_out_count: got %0d want %0d", out_q.size(), SAMPLES); end
    n_vec++; if (bo != 0) begin n_fail++; $display("FAIL bp_out_data: %0d bad samples, want 0", bo); end
    n_vec++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stall_stable: %0d changes during stall, want 0", stall_viol); end
    n_vec++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL bp_frame_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_input_gaps();
    int bw, bo;
    fill_random(); clear_rec();
    drive_frame(1'b1, 1'b0, 1'b0);
    bw = bad_writes(); bo = bad_outputs();
    n_vec++; if (bw != 0) begin n_fail++; $display("FAIL gap_write_chunks: %0d bad, want 0", bw); end
    n_vec++; if (proto_viol != 0) begin n_fail++; $display("FAIL gap_ready: %0d violations want 0", proto_viol); end
    n_vec++; if (bo != 0) begin n_fail++; $display("FAIL gap_out_data: %0d bad samples, want 0", bo); end
    n_vec++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL gap_frame_count: got %0d want 3", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int bw, bo;
    fill_random(); clear_rec();
    drive_frame(1'b0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_vec++; if ({busy, s_in_ready, frame_count} !== {2'b01, 16'd0}) begin
      n_fail++; $display("FAIL rm_after_reset: busy=%b ready=%b fc=%0d want 0/1/0", busy, s_in_ready, frame_count); end
    clear_rec();
    repeat (300) @(posedge clk);
    #1;
    n_vec++; if (start_cnt != 0 || wr_idx_q.size() != 0 || out_q.size() != 0) begin
      n_fail++; $display("FAIL rm_quiet: got %0d starts %0d writes %0d outs want 0", start_cnt, wr_idx_q.size(), out_q.size()); end
    fill_random(); clear_rec();
    drive_frame(1'b0, 1'b0, 1'b0);
    bw = bad_writes(); bo = bad_outputs();
    n_vec++; if (bw != 0) begin n_fail++; $display("FAIL rm_next_writes: %0d bad, want 0", bw); end
    n_vec++; if (bo != 0) begin n_fail++; $display("FAIL rm_next_out: %0d bad samples, want 0", bo); end
    n_vec++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rm_frame_count: got %0d want 1", frame_count); end
  endtask

`ifdef STREAMER_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hang = 1'b1;
    fill_random(); clear_rec();
    drive_frame(1'b0, 1'b0, 1'b1);
    repeat (99) @(posedge clk);
    #1;
    n_vec++; if ({timeout_err, busy} !== 2'b01) begin n_fail++; $display("FAIL to_before: err/busy=%b want 01", {timeout_err, busy}); end
    @(posedge clk); #1;
    n_vec++; if ({timeout_err, busy, s_in_ready} !== 3'b101) begin
      n_fail++; $display("FAIL to_expire: err/busy/ready=%b want 101", {timeout_err, busy, s_in_ready}); end
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (out_q.size() != 0 || frame_count !== 16'd0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_dropped: outs=%0d fc=%0d err=%b want 0/0/1", out_q.size(), frame_count, timeout_err); end
    hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_input_gaps();
    test_reset_mid_frame();
`ifdef STREAMER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
